// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
//
// Serial UART transmitter for one byte per valid/ready handshake. Each
// accepted byte is sent as: start bit (0), 8 data bits LSB first, an
// optional parity bit, and one stop bit (1). A bit-period counter derives
// the baud rate from the system clock.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY       : 0 = none, 1 = even, 2 = odd (other values unsupported)
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   ena      in   enables acceptance of new bytes (frames in flight finish)
//   in_data  in   byte to transmit, sampled on the accept edge only
//   in_valid in   upstream offers a byte
//   in_ready out  high when idle and enabled (combinational from state)
//   tx       out  serial line, idle high, registered
//   busy     out  high while a frame is on the line, registered
// ---------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam bit            ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          bit_done;

  assign in_ready = ena && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    // The bit-period counter free-runs in every frame state and wraps at
    // the end of each bit.
    if (state_q != S_IDLE) begin
      cnt_d = bit_done ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          // Parity is frozen from the captured byte because the shift
          // register is consumed while the data bits go out.
          par_d   = (^in_data) ^ ODD_PARITY;
          idx_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is derived from the *next* state so the registered tx
  // always shows the level belonging to the current state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
